// File: rtl/connect_n_core.sv
// connect_n_core: parametrised Connect-N game engine.
// Holds the board, drops tokens into the lowest free row of a column,
// alternates players and runs a four-cycle win/draw scan after each drop.
// Optional feature macro: CONNECT_WIN_HIGHLIGHT_EN (latches the winning run
// into win_mask; when undefined win_mask is tied low).
//
// Handshake: a move is taken on any rising edge where move_valid && move_ready.
// move_col is sampled on that same edge; move_valid carries no meaning while
// move_ready is low and the requester must hold or re-present the request.
module connect_n_core #(
    parameter int ROWS    = 6,
    parameter int COLS    = 8,
    parameter int WIN_LEN = 4
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      new_game,
    input  logic                      move_valid,
    input  logic [$clog2(COLS)-1:0]   move_col,
    output logic                      move_ready,
    output logic                      move_reject,
    output logic                      player_turn,
    output logic [ROWS*COLS-1:0]      board_red,
    output logic [ROWS*COLS-1:0]      board_grn,
    output logic [$clog2(ROWS)-1:0]   last_row,
    output logic [$clog2(COLS)-1:0]   last_col,
    output logic                      game_over,
    output logic [1:0]                winner,
    output logic [ROWS*COLS-1:0]      win_mask
);

    localparam int CELLS = ROWS * COLS;
    localparam int RW    = $clog2(ROWS);
    localparam int CW    = $clog2(COLS);
    localparam int IW    = $clog2(CELLS);
    localparam int NW    = $clog2(CELLS + 1);

    localparam logic [NW-1:0] FULL_COUNT = CELLS[NW-1:0];
    localparam logic [CW:0]   COL_LIMIT  = COLS[CW:0];

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_SCAN = 2'd1;
    localparam logic [1:0] ST_OVER = 2'd2;

    // Flat cell index: row-major with row 0 at the bottom.
    function automatic logic [IW-1:0] cidx(input int r, input int c);
        return IW'(r * COLS + c);
    endfunction

    logic [1:0]       state_q, state_d;
    logic [1:0]       dir_q, dir_d;
    logic [CELLS-1:0] board_red_q, board_red_d;
    logic [CELLS-1:0] board_grn_q, board_grn_d;
    logic             player_turn_q, player_turn_d;
    logic [NW-1:0]    count_q, count_d;
    logic [RW-1:0]    last_row_q, last_row_d;
    logic [CW-1:0]    last_col_q, last_col_d;
    logic             reject_q, reject_d;
    logic             hit_q, hit_d;
    logic [1:0]       winner_q, winner_d;
    logic             over_q, over_d;
`ifdef CONNECT_WIN_HIGHLIGHT_EN
    logic [CELLS-1:0] mask_q, mask_d;
    logic [CELLS-1:0] scan_mask;
`endif

    logic [CELLS-1:0] occupied;
    logic             col_in_range;
    logic             col_has_room;
    logic [RW-1:0]    free_row;

    logic [CELLS-1:0] own;
    logic             scan_hit;
    int               run_len;
    int               dr, dc, rr, cc, sg;
    logic             alive;

    // Lowest empty row of the requested column; no room if column is full or out of range.
    always_comb begin
        occupied     = board_red_q | board_grn_q;
        col_in_range = ({1'b0, move_col} < COL_LIMIT);
        col_has_room = 1'b0;
        free_row     = '0;
        if (col_in_range) begin
            // Top-down so the last empty cell seen is the lowest one.
            for (int r = ROWS - 1; r >= 0; r--) begin
                if (!occupied[cidx(r, int'(move_col))]) begin
                    col_has_room = 1'b1;
                    free_row     = RW'(r);
                end
            end
        end
    end

    // Run length through the last placement along the current scan direction.
    always_comb begin
        own = player_turn_q ? board_grn_q : board_red_q;
        case (dir_q)
            2'd0:    begin dr = 0; dc = 1;  end
            2'd1:    begin dr = 1; dc = 0;  end
            2'd2:    begin dr = 1; dc = 1;  end
            default: begin dr = 1; dc = -1; end
        endcase
        run_len = 1;
        rr      = 0;
        cc      = 0;
        sg      = 1;
        alive   = 1'b1;
`ifdef CONNECT_WIN_HIGHLIGHT_EN
        scan_mask = '0;
        scan_mask[cidx(int'(last_row_q), int'(last_col_q))] = 1'b1;
`endif
        // Both senses, each capped at WIN_LEN-1 steps and stopped at the edge
        // or at the first cell not owned by the mover.
        for (int s = 0; s < 2; s++) begin
            sg    = (s == 0) ? 1 : -1;
            alive = 1'b1;
            for (int k = 1; k < WIN_LEN; k++) begin
                rr = int'(last_row_q) + sg * k * dr;
                cc = int'(last_col_q) + sg * k * dc;
                if (alive && rr >= 0 && rr < ROWS && cc >= 0 && cc < COLS) begin
                    if (own[cidx(rr, cc)]) begin
                        run_len = run_len + 1;
`ifdef CONNECT_WIN_HIGHLIGHT_EN
                        scan_mask[cidx(rr, cc)] = 1'b1;
`endif
                    end else begin
                        alive = 1'b0;
                    end
                end else begin
                    alive = 1'b0;
                end
            end
        end
        scan_hit = (run_len >= WIN_LEN);
    end

    // Game FSM: accept/reject moves, step the scan, decide win/draw/turn.
    always_comb begin
        state_d       = state_q;
        dir_d         = dir_q;
        board_red_d   = board_red_q;
        board_grn_d   = board_grn_q;
        player_turn_d = player_turn_q;
        count_d       = count_q;
        last_row_d    = last_row_q;
        last_col_d    = last_col_q;
        reject_d      = 1'b0;
        hit_d         = hit_q;
        winner_d      = winner_q;
        over_d        = over_q;
`ifdef CONNECT_WIN_HIGHLIGHT_EN
        mask_d        = mask_q;
`endif
        if (new_game) begin
            state_d       = ST_IDLE;
            dir_d         = 2'd0;
            board_red_d   = '0;
            board_grn_d   = '0;
            player_turn_d = 1'b0;
            count_d       = '0;
            hit_d         = 1'b0;
            winner_d      = 2'b00;
            over_d        = 1'b0;
`ifdef CONNECT_WIN_HIGHLIGHT_EN
            mask_d        = '0;
`endif
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (move_valid) begin
                        if (!col_has_room) begin
                            reject_d = 1'b1;
                        end else begin
                            if (player_turn_q)
                                board_grn_d[cidx(int'(free_row), int'(move_col))] = 1'b1;
                            else
                                board_red_d[cidx(int'(free_row), int'(move_col))] = 1'b1;
                            last_row_d = free_row;
                            last_col_d = move_col;
                            count_d    = count_q + 1'b1;
                            hit_d      = 1'b0;
                            dir_d      = 2'd0;
                            state_d    = ST_SCAN;
                        end
                    end
                end
                ST_SCAN: begin
                    // Only the first hit is kept so the mask shows one run.
                    if (scan_hit && !hit_q) begin
                        hit_d = 1'b1;
`ifdef CONNECT_WIN_HIGHLIGHT_EN
                        mask_d = scan_mask;
`endif
                    end
                    if (dir_q == 2'd3) begin
                        if (hit_q || scan_hit) begin
                            winner_d = player_turn_q ? 2'b10 : 2'b01;
                            over_d   = 1'b1;
                            state_d  = ST_OVER;
                        end else if (count_q == FULL_COUNT) begin
                            winner_d = 2'b11;
                            over_d   = 1'b1;
                            state_d  = ST_OVER;
                        end else begin
                            player_turn_d = ~player_turn_q;
                            state_d       = ST_IDLE;
                        end
                    end else begin
                        dir_d = dir_q + 2'd1;
                    end
                end
                ST_OVER: begin
                    // Parked until new_game or reset.
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= ST_IDLE;
            dir_q         <= 2'd0;
            board_red_q   <= '0;
            board_grn_q   <= '0;
            player_turn_q <= 1'b0;
            count_q       <= '0;
            last_row_q    <= '0;
            last_col_q    <= '0;
            reject_q      <= 1'b0;
            hit_q         <= 1'b0;
            winner_q      <= 2'b00;
            over_q        <= 1'b0;
`ifdef CONNECT_WIN_HIGHLIGHT_EN
            mask_q        <= '0;
`endif
        end else begin
            state_q       <= state_d;
            dir_q         <= dir_d;
            board_red_q   <= board_red_d;
            board_grn_q   <= board_grn_d;
            player_turn_q <= player_turn_d;
            count_q       <= count_d;
            last_row_q    <= last_row_d;
            last_col_q    <= last_col_d;
            reject_q      <= reject_d;
            hit_q         <= hit_d;
            winner_q      <= winner_d;
            over_q        <= over_d;
`ifdef CONNECT_WIN_HIGHLIGHT_EN
            mask_q        <= mask_d;
`endif
        end
    end

    assign move_ready  = (state_q == ST_IDLE);
    assign move_reject = reject_q;
    assign player_turn = player_turn_q;
    assign board_red   = board_red_q;
    assign board_grn   = board_grn_q;
    assign last_row    = last_row_q;
    assign last_col    = last_col_q;
    assign game_over   = over_q;
    assign winner      = winner_q;
`ifdef CONNECT_WIN_HIGHLIGHT_EN
    assign win_mask    = mask_q;
`else
    assign win_mask    = '0;
`endif

endmodule

// File: tb/tb_connect_n_core.sv
// Directed bench for connect_n_core: default 6x8 board plus a 2x2 board
// (draw) and a 2x3 board (column select beyond COLS, which a 3-bit select
// cannot express on an 8-column board).
module tb_connect_n_core;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_cmp = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    // Default 6x8, connect-4.
    logic        ng = 1'b0, mv = 1'b0;
    logic [2:0]  mc = '0;
    logic        ready, rej, turn, gover;
    logic [47:0] bred, bgrn, wmask;
    logic [2:0]  lrow, lcol;
    logic [1:0]  win;

    // 2x2, connect-3.
    logic        ng_s = 1'b0, mv_s = 1'b0;
    logic [0:0]  mc_s = '0;
    logic        ready_s, rej_s, turn_s, gover_s;
    logic [3:0]  bred_s, bgrn_s, wmask_s;
    logic [0:0]  lrow_s, lcol_s;
    logic [1:0]  win_s;

    // 2x3, connect-3.
    logic        ng_r = 1'b0, mv_r = 1'b0;
    logic [1:0]  mc_r = '0;
    logic        ready_r, rej_r, turn_r, gover_r;
    logic [5:0]  bred_r, bgrn_r, wmask_r;
    logic [0:0]  lrow_r;
    logic [1:0]  lcol_r;
    logic [1:0]  win_r;

    logic [47:0] exp_m;

    connect_n_core dut (
        .clk(clk), .reset(rst_n), .new_game(ng), .move_valid(mv), .move_col(mc),
        .move_ready(ready), .move_reject(rej), .player_turn(turn),
        .board_red(bred), .board_grn(bgrn), .last_row(lrow), .last_col(lcol),
        .game_over(gover), .winner(win), .win_mask(wmask)
    );

    connect_n_core #(.ROWS(2), .COLS(2), .WIN_LEN(3)) dut_s (
        .clk(clk), .reset(rst_n), .new_game(ng_s), .move_valid(mv_s), .move_col(mc_s),
        .move_ready(ready_s), .move_reject(rej_s), .player_turn(turn_s),
        .board_red(bred_s), .board_grn(bgrn_s), .last_row(lrow_s), .last_col(lcol_s),
        .game_over(gover_s), .winner(win_s), .win_mask(wmask_s)
    );

    connect_n_core #(.ROWS(2), .COLS(3), .WIN_LEN(3)) dut_r (
        .clk(clk), .reset(rst_n), .new_game(ng_r), .move_valid(mv_r), .move_col(mc_r),
        .move_ready(ready_r), .move_reject(rej_r), .player_turn(turn_r),
        .board_red(bred_r), .board_grn(bgrn_r), .last_row(lrow_r), .last_col(lcol_r),
        .game_over(gover_r), .winner(win_r), .win_mask(wmask_r)
    );

    // Advance one clock and sample 1 ns after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_main();
        ng = 1'b1;
        step();
        ng = 1'b0;
    endtask

    // Wait (bounded) until the main engine is idle again or the game is decided.
    task automatic wait_idle();
        int i;
        i = 0;
        while (!ready && !gover && i < 20) begin
            step();
            i++;
        end
        n_cmp++;
        if (!ready && !gover) begin
            n_err++;
            $display("FAIL ready_timeout: ready=%b game_over=%b after %0d cycles", ready, gover, i);
        end
    endtask

    task automatic drop(input int col);
        mv = 1'b1;
        mc = 3'(col);
        step();
        mv = 1'b0;
        wait_idle();
    endtask

    task automatic drop_s(input int col);
        int i;
        mv_s = 1'b1;
        mc_s = 1'(col);
        step();
        mv_s = 1'b0;
        i = 0;
        while (!ready_s && !gover_s && i < 20) begin
            step();
            i++;
        end
        n_cmp++;
        if (!ready_s && !gover_s) begin
            n_err++;
            $display("FAIL ready_timeout_s: ready=%b game_over=%b", ready_s, gover_s);
        end
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        step();
        n_cmp++; if (bred !== 48'h0) begin n_err++; $display("FAIL rst_board_red: got %h want 0", bred); end
        n_cmp++; if (bgrn !== 48'h0) begin n_err++; $display("FAIL rst_board_grn: got %h want 0", bgrn); end
        n_cmp++; if (turn !== 1'b0) begin n_err++; $display("FAIL rst_turn: got %b want 0", turn); end
        n_cmp++; if (ready !== 1'b1) begin n_err++; $display("FAIL rst_ready: got %b want 1", ready); end
        n_cmp++; if (rej !== 1'b0) begin n_err++; $display("FAIL rst_reject: got %b want 0", rej); end
        n_cmp++; if (lrow !== 3'd0 || lcol !== 3'd0) begin n_err++; $display("FAIL rst_last: got r%0d c%0d want r0 c0", lrow, lcol); end
        n_cmp++; if (gover !== 1'b0 || win !== 2'b00) begin n_err++; $display("FAIL rst_result: got over=%b win=%b want 0/00", gover, win); end
        n_cmp++; if (wmask !== 48'h0) begin n_err++; $display("FAIL rst_mask: got %h want 0", wmask); end
    endtask

    task automatic test_first_drop();
        mv = 1'b1;
        mc = 3'd3;
        step();
        mv = 1'b0;
        n_cmp++; if (bred !== 48'h8) begin n_err++; $display("FAIL first_board: got %h want 8", bred); end
        n_cmp++; if (lrow !== 3'd0 || lcol !== 3'd3) begin n_err++; $display("FAIL first_last: got r%0d c%0d want r0 c3", lrow, lcol); end
        n_cmp++; if (ready !== 1'b0) begin n_err++; $display("FAIL first_busy_e0: got %b want 0", ready); end
        for (int i = 1; i <= 3; i++) begin
            step();
            n_cmp++; if (ready !== 1'b0) begin n_err++; $display("FAIL first_busy_e%0d: got %b want 0", i, ready); end
        end
        n_cmp++; if (turn !== 1'b0) begin n_err++; $display("FAIL first_turn_early: got %b want 0", turn); end
        step();
        n_cmp++; if (ready !== 1'b1) begin n_err++; $display("FAIL first_ready_e4: got %b want 1", ready); end
        n_cmp++; if (turn !== 1'b1) begin n_err++; $display("FAIL first_turn_e4: got %b want 1", turn); end
    endtask

    task automatic test_column_full();
        clear_main();
        for (int i = 0; i < 6; i++) drop(0);
        // Two back-to-back requests into the full column: each rejects.
        mv = 1'b1;
        mc = 3'd0;
        step();
        n_cmp++; if (rej !== 1'b1) begin n_err++; $display("FAIL full_reject: got %b want 1", rej); end
        n_cmp++; if (ready !== 1'b1) begin n_err++; $display("FAIL full_ready: got %b want 1", ready); end
        n_cmp++; if (bred !== 48'h000100010001) begin n_err++; $display("FAIL full_board_red: got %h want 000100010001", bred); end
        n_cmp++; if (bgrn !== 48'h010001000100) begin n_err++; $display("FAIL full_board_grn: got %h want 010001000100", bgrn); end
        n_cmp++; if (turn !== 1'b0) begin n_err++; $display("FAIL full_turn: got %b want 0", turn); end
        step();
        mv = 1'b0;
        n_cmp++; if (rej !== 1'b1) begin n_err++; $display("FAIL full_reject_b2b: got %b want 1", rej); end
        step();
        n_cmp++; if (rej !== 1'b0) begin n_err++; $display("FAIL full_reject_end: got %b want 0", rej); end
        // Column beyond COLS on the 3-column board.
        mv_r = 1'b1;
        mc_r = 2'd3;
        step();
        mv_r = 1'b0;
        n_cmp++; if (rej_r !== 1'b1) begin n_err++; $display("FAIL range_reject: got %b want 1", rej_r); end
        n_cmp++; if (ready_r !== 1'b1 || bred_r !== 6'h0 || turn_r !== 1'b0) begin n_err++; $display("FAIL range_state: got rdy=%b red=%h turn=%b want 1/00/0", ready_r, bred_r, turn_r); end
        step();
        n_cmp++; if (rej_r !== 1'b0) begin n_err++; $display("FAIL range_reject_end: got %b want 0", rej_r); end
    endtask

    task automatic test_horizontal();
        clear_main();
        drop(3); drop(6); drop(4); drop(6); drop(5); drop(6);
        n_cmp++; if (gover !== 1'b0) begin n_err++; $display("FAIL horiz_early: got %b want 0", gover); end
        drop(2);
`ifdef CONNECT_WIN_HIGHLIGHT_EN
        exp_m = 48'h3C;
`else
        exp_m = 48'h0;
`endif
        n_cmp++; if (win !== 2'b01 || gover !== 1'b1) begin n_err++; $display("FAIL horiz_win: got win=%b over=%b want 01/1", win, gover); end
        n_cmp++; if (bred !== 48'h3C || bgrn !== 48'h404040) begin n_err++; $display("FAIL horiz_board: got red=%h grn=%h want 3c/404040", bred, bgrn); end
        n_cmp++; if (wmask !== exp_m) begin n_err++; $display("FAIL horiz_mask: got %h want %h", wmask, exp_m); end
        n_cmp++; if (ready !== 1'b0) begin n_err++; $display("FAIL horiz_ready: got %b want 0", ready); end
        mv = 1'b1;
        mc = 3'd0;
        step();
        step();
        mv = 1'b0;
        n_cmp++; if (rej !== 1'b0 || bred !== 48'h3C || gover !== 1'b1) begin n_err++; $display("FAIL horiz_ignore: got rej=%b red=%h over=%b want 0/3c/1", rej, bred, gover); end
    endtask

    task automatic test_vertical();
        clear_main();
        drop(0); drop(6); drop(1); drop(6); drop(0); drop(6); drop(1); drop(6);
`ifdef CONNECT_WIN_HIGHLIGHT_EN
        exp_m = 48'h40404040;
`else
        exp_m = 48'h0;
`endif
        n_cmp++; if (win !== 2'b10 || gover !== 1'b1) begin n_err++; $display("FAIL vert_win: got win=%b over=%b want 10/1", win, gover); end
        n_cmp++; if (bgrn !== 48'h40404040 || bred !== 48'h303) begin n_err++; $display("FAIL vert_board: got grn=%h red=%h want 40404040/303", bgrn, bred); end
        n_cmp++; if (turn !== 1'b1) begin n_err++; $display("FAIL vert_turn: got %b want 1", turn); end
        n_cmp++; if (wmask !== exp_m) begin n_err++; $display("FAIL vert_mask: got %h want %h", wmask, exp_m); end
    endtask

    task automatic test_diagonal();
        clear_main();
        drop(0); drop(1); drop(1); drop(2); drop(3); drop(2); drop(2); drop(3); drop(5); drop(3);
        n_cmp++; if (gover !== 1'b0) begin n_err++; $display("FAIL diag_early: got %b want 0", gover); end
        drop(3);
`ifdef CONNECT_WIN_HIGHLIGHT_EN
        exp_m = 48'h8040201;
`else
        exp_m = 48'h0;
`endif
        n_cmp++; if (win !== 2'b01 || gover !== 1'b1) begin n_err++; $display("FAIL diag_win: got win=%b over=%b want 01/1", win, gover); end
        n_cmp++; if (bred !== 48'h8040229) begin n_err++; $display("FAIL diag_board: got %h want 8040229", bred); end
        n_cmp++; if (lrow !== 3'd3 || lcol !== 3'd3) begin n_err++; $display("FAIL diag_last: got r%0d c%0d want r3 c3", lrow, lcol); end
        n_cmp++; if (wmask !== exp_m) begin n_err++; $display("FAIL diag_mask: got %h want %h", wmask, exp_m); end
        // Mirror image: antidiagonal through (3,0),(2,1),(1,2),(0,3).
        clear_main();
        drop(3); drop(2); drop(2); drop(1); drop(0); drop(1); drop(1); drop(0); drop(6); drop(0);
        n_cmp++; if (gover !== 1'b0) begin n_err++; $display("FAIL anti_early: got %b want 0", gover); end
        drop(0);
`ifdef CONNECT_WIN_HIGHLIGHT_EN
        exp_m = 48'h1020408;
`else
        exp_m = 48'h0;
`endif
        n_cmp++; if (win !== 2'b01 || gover !== 1'b1) begin n_err++; $display("FAIL anti_win: got win=%b over=%b want 01/1", win, gover); end
        n_cmp++; if (bred !== 48'h1020449) begin n_err++; $display("FAIL anti_board: got %h want 1020449", bred); end
        n_cmp++; if (wmask !== exp_m) begin n_err++; $display("FAIL anti_mask: got %h want %h", wmask, exp_m); end
    endtask

    task automatic test_draw();
        ng_s = 1'b1;
        step();
        ng_s = 1'b0;
        drop_s(0); drop_s(1); drop_s(0);
        n_cmp++; if (gover_s !== 1'b0 || ready_s !== 1'b1) begin n_err++; $display("FAIL draw_early: got over=%b rdy=%b want 0/1", gover_s, ready_s); end
        drop_s(1);
        n_cmp++; if (win_s !== 2'b11 || gover_s !== 1'b1) begin n_err++; $display("FAIL draw_result: got win=%b over=%b want 11/1", win_s, gover_s); end
        n_cmp++; if (bred_s !== 4'b0101 || bgrn_s !== 4'b1010) begin n_err++; $display("FAIL draw_board: got red=%b grn=%b want 0101/1010", bred_s, bgrn_s); end
        n_cmp++; if (turn_s !== 1'b1 || wmask_s !== 4'b0000) begin n_err++; $display("FAIL draw_turn_mask: got turn=%b mask=%b want 1/0000", turn_s, wmask_s); end
    endtask

    task automatic test_new_game_mid_scan();
        clear_main();
        drop(3); drop(6); drop(4); drop(6); drop(5); drop(6);
        mv = 1'b1;
        mc = 3'd2;
        step();
        mv = 1'b0;
        ng = 1'b1;
        step();
        ng = 1'b0;
        n_cmp++; if (gover !== 1'b0 || win !== 2'b00) begin n_err++; $display("FAIL ng_result: got over=%b win=%b want 0/00", gover, win); end
        n_cmp++; if (bred !== 48'h0 || bgrn !== 48'h0) begin n_err++; $display("FAIL ng_board: got red=%h grn=%h want 0/0", bred, bgrn); end
        n_cmp++; if (turn !== 1'b0 || ready !== 1'b1) begin n_err++; $display("FAIL ng_turn_ready: got turn=%b rdy=%b want 0/1", turn, ready); end
        n_cmp++; if (wmask !== 48'h0) begin n_err++; $display("FAIL ng_mask: got %h want 0", wmask); end
        repeat (5) step();
        n_cmp++; if (gover !== 1'b0 || ready !== 1'b1) begin n_err++; $display("FAIL ng_settled: got over=%b rdy=%b want 0/1", gover, ready); end
    endtask

    task automatic test_reset_mid_scan();
        clear_main();
        drop(5); drop(5);
        mv = 1'b1;
        mc = 3'd5;
        step();
        mv = 1'b0;
        n_cmp++; if (lrow !== 3'd2 || lcol !== 3'd5) begin n_err++; $display("FAIL rms_last_pre: got r%0d c%0d want r2 c5", lrow, lcol); end
        rst_n = 1'b0;
        #2;
        n_cmp++; if (bred !== 48'h0 || bgrn !== 48'h0) begin n_err++; $display("FAIL rms_board: got red=%h grn=%h want 0/0", bred, bgrn); end
        n_cmp++; if (ready !== 1'b1 || rej !== 1'b0 || turn !== 1'b0) begin n_err++; $display("FAIL rms_ctrl: got rdy=%b rej=%b turn=%b want 1/0/0", ready, rej, turn); end
        n_cmp++; if (lrow !== 3'd0 || lcol !== 3'd0) begin n_err++; $display("FAIL rms_last: got r%0d c%0d want r0 c0", lrow, lcol); end
        n_cmp++; if (gover !== 1'b0 || win !== 2'b00 || wmask !== 48'h0) begin n_err++; $display("FAIL rms_result: got over=%b win=%b mask=%h want 0/00/0", gover, win, wmask); end
        step();
        rst_n = 1'b1;
        step();
        drop(4);
        n_cmp++; if (bred !== 48'h10 || bgrn !== 48'h0 || turn !== 1'b1) begin n_err++; $display("FAIL rms_after: got red=%h grn=%h turn=%b want 10/0/1", bred, bgrn, turn); end
    endtask

    initial begin
        test_reset();
        test_first_drop();
        test_column_full();
        test_horizontal();
        test_vertical();
        test_diagonal();
        test_draw();
        test_new_game_mid_scan();
        test_reset_mid_scan();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, compared=%0d", n_cmp);
        $fatal(1, "watchdog expired");
    end

endmodule
